alu_instr_sequencer: RTL and testbench

//  Hardwired control FSM that drives the 32-bit bus datapath through fetch (T0-T2)
//  and execute (T3-T6) for register-register ALU instructions. It replaces the

---
 rtl/alu_instr_sequencer_pkg.sv | 121 ++++++++++++
 rtl/alu_instr_sequencer_if.sv | 30 +++
 rtl/alu_instr_sequencer_decode.sv | 71 +++++++
 rtl/alu_instr_sequencer.sv | 92 +++++++++
 tb/tb_alu_instr_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants, state encoding, IR field layout and decode helpers for the
// register-register ALU instruction sequencer.
package alu_instr_sequencer_pkg;

    localparam int unsigned NREGS  = 16;
    localparam int unsigned OPW    = 5;
    localparam int unsigned ALUW   = 4;
    localparam int unsigned IRW    = 32;
    localparam int unsigned RIDXW  = 4;
    localparam int unsigned STW    = 4;
    localparam int unsigned OP_LSB = IRW - OPW;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;

    localparam logic [STW-1:0] ST_IDLE = 4'd0;
    localparam logic [STW-1:0] ST_T0   = 4'd1;
    localparam logic [STW-1:0] ST_T1   = 4'd2;
    localparam logic [STW-1:0] ST_T1W  = 4'd3;
    localparam logic [STW-1:0] ST_T2   = 4'd4;
    localparam logic [STW-1:0] ST_T3   = 4'd5;
    localparam logic [STW-1:0] ST_T4   = 4'd6;
    localparam logic [STW-1:0] ST_T5   = 4'd7;
    localparam logic [STW-1:0] ST_T6   = 4'd8;
    localparam logic [STW-1:0] ST_HALT = 4'd9;

    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_AND  = 5'd5;
    localparam logic [OPW-1:0] OP_OR   = 5'd6;
    localparam logic [OPW-1:0] OP_SHR  = 5'd7;
    localparam logic [OPW-1:0] OP_SHL  = 5'd8;
    localparam logic [OPW-1:0] OP_ROR  = 5'd9;
    localparam logic [OPW-1:0] OP_ROL  = 5'd10;
    localparam logic [OPW-1:0] OP_MUL  = 5'd15;
    localparam logic [OPW-1:0] OP_DIV  = 5'd16;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    // Zero is reserved so an idle alu_op never looks like a real function.
    localparam logic [ALUW-1:0] ALU_NONE = 4'd0;
    localparam logic [ALUW-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALUW-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALUW-1:0] ALU_AND  = 4'd3;
    localparam logic [ALUW-1:0] ALU_OR   = 4'd4;
    localparam logic [ALUW-1:0] ALU_SHR  = 4'd5;
    localparam logic [ALUW-1:0] ALU_SHL  = 4'd6;
    localparam logic [ALUW-1:0] ALU_ROR  = 4'd7;
    localparam logic [ALUW-1:0] ALU_ROL  = 4'd8;
    localparam logic [ALUW-1:0] ALU_MUL  = 4'd9;
    localparam logic [ALUW-1:0] ALU_DIV  = 4'd10;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [RIDXW-1:0] ra;
        logic [RIDXW-1:0] rb;
        logic [RIDXW-1:0] rc;
    } ir_fields_t;

    typedef struct packed {
        logic             pc_out;
        logic             zlow_out;
        logic             zhigh_out;
        logic             mdr_out;
        logic             hi_out;
        logic             lo_out;
        logic             mar_in;
        logic             mdr_in;
        logic             pc_in;
        logic             ir_in;
        logic             y_in;
        logic             z_in;
        logic             hi_in;
        logic             lo_in;
        logic             read;
        logic             inc_pc;
        logic             busy;
        logic             illegal;
        logic [NREGS-1:0] reg_out;
        logic [NREGS-1:0] reg_in;
        logic [ALUW-1:0]  alu_op;
    } ctrl_en_t;

    function automatic logic op_is_alu(input logic [OPW-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
    endfunction

    function automatic logic op_is_muldiv(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic reg_ok(input logic [RIDXW-1:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    // MUL/DIV write LO/HI, so their Ra field is don't-care.
    function automatic logic fields_legal(input ir_fields_t f);
        return (op_is_alu(f.op) && reg_ok(f.ra) && reg_ok(f.rb) && reg_ok(f.rc)) ||
               (op_is_muldiv(f.op) && reg_ok(f.rb) && reg_ok(f.rc));
    endfunction

    function automatic logic [ALUW-1:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic logic [NREGS-1:0] reg_sel(input logic [RIDXW-1:0] idx);
        return NREGS'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the 32-bit bus datapath (slave).
interface alu_instr_sequencer_if;
    import alu_instr_sequencer_pkg::*;

    logic             run;
    logic             mem_rdy;
    logic [IRW-1:0]   ir;
    logic             PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic             MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin;
    logic             Read, IncPC;
    logic [NREGS-1:0] reg_out;
    logic [NREGS-1:0] reg_in;
    logic [ALUW-1:0]  alu_op;
    logic             busy;
    logic             illegal;

    modport master (
        input  run, mem_rdy, ir,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        output MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin,
        output Read, IncPC, reg_out, reg_in, alu_op, busy, illegal
    );

    modport slave (
        output run, mem_rdy, ir,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
        input  MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin,
        input  Read, IncPC, reg_out, reg_in, alu_op, busy, illegal
    );
endinterface

// File: rtl/alu_instr_sequencer_decode.sv
// Combinational map from {state, latched IR fields} to the datapath enable vector.
module alu_instr_sequencer_decode
    import alu_instr_sequencer_pkg::*;
(
    input  logic [STW-1:0] state_i,
    input  ir_fields_t     fields_i,
    output ctrl_en_t       en_c
);

    logic legal;
    logic muldiv;

    assign legal  = fields_legal(fields_i);
    assign muldiv = op_is_muldiv(fields_i.op);

    always_comb begin
        en_c      = '0;
        en_c.busy = (state_i != ST_IDLE) && (state_i != ST_HALT);
        case (state_i)
            ST_T0: begin
                en_c.pc_out = 1'b1;
                en_c.mar_in = 1'b1;
                en_c.inc_pc = 1'b1;
                en_c.z_in   = 1'b1;
                en_c.alu_op = ALU_ADD;
            end
            ST_T1: begin
                en_c.zlow_out = 1'b1;
                en_c.pc_in    = 1'b1;
                en_c.read     = 1'b1;
                en_c.mdr_in   = 1'b1;
            end
            // Memory wait: keep the read open but do not reload PC a second time.
            ST_T1W: begin
                en_c.read   = 1'b1;
                en_c.mdr_in = 1'b1;
            end
            ST_T2: begin
                en_c.mdr_out = 1'b1;
                en_c.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (legal) begin
                    en_c.reg_out = reg_sel(fields_i.rb);
                    en_c.y_in    = 1'b1;
                end else begin
                    en_c.illegal = 1'b1;
                end
            end
            ST_T4: begin
                en_c.reg_out = reg_sel(fields_i.rc);
                en_c.z_in    = 1'b1;
                en_c.alu_op  = alu_code(fields_i.op);
            end
            ST_T5: begin
                en_c.zlow_out = 1'b1;
                if (muldiv) begin
                    en_c.lo_in = 1'b1;
                end else begin
                    en_c.reg_in = reg_sel(fields_i.ra);
                end
            end
            ST_T6: begin
                en_c.zhigh_out = 1'b1;
                en_c.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control FSM: state register, IR field latches and registered enables.
module alu_instr_sequencer
    import alu_instr_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    alu_instr_sequencer_if.master bus
);

    logic [STW-1:0] state_q, state_d;
    ir_fields_t     fields_q, fields_d, ir_f;
    ctrl_en_t       en_q, en_d;
    logic           unused_ir;

    assign ir_f.op   = bus.ir[OP_LSB +: OPW];
    assign ir_f.ra   = bus.ir[RA_LSB +: RIDXW];
    assign ir_f.rb   = bus.ir[RB_LSB +: RIDXW];
    assign ir_f.rc   = bus.ir[RC_LSB +: RIDXW];
    assign unused_ir = ^bus.ir[RC_LSB-1:0];

    // Next state and IR field capture.
    always_comb begin
        state_d  = state_q;
        fields_d = fields_q;
        case (state_q)
            ST_IDLE: if (bus.run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1,
            ST_T1W:  state_d = bus.mem_rdy ? ST_T2 : ST_T1W;
            ST_T2: begin
                fields_d = ir_f;
                state_d  = (ir_f.op == OP_HALT) ? ST_HALT : ST_T3;
            end
            ST_T3:   state_d = fields_legal(fields_q) ? ST_T4 : ST_T0;
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (op_is_muldiv(fields_q.op)) state_d = ST_T6;
                else                            state_d = bus.run ? ST_T0 : ST_IDLE;
            end
            ST_T6:   state_d = bus.run ? ST_T0 : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Enables are decoded from the next state so the registered outputs line up with state_q.
    alu_instr_sequencer_decode u_decode (
        .state_i  (state_d),
        .fields_i (fields_d),
        .en_c     (en_d)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            fields_q <= '0;
            en_q     <= '0;
        end else begin
            state_q  <= state_d;
            fields_q <= fields_d;
            en_q     <= en_d;
        end
    end

    assign bus.PCout    = en_q.pc_out;
    assign bus.Zlowout  = en_q.zlow_out;
    assign bus.Zhighout = en_q.zhigh_out;
    assign bus.MDRout   = en_q.mdr_out;
    assign bus.HIout    = en_q.hi_out;
    assign bus.LOout    = en_q.lo_out;
    assign bus.MARin    = en_q.mar_in;
    assign bus.MDRin    = en_q.mdr_in;
    assign bus.PCin     = en_q.pc_in;
    assign bus.IRin     = en_q.ir_in;
    assign bus.Yin      = en_q.y_in;
    assign bus.Zin      = en_q.z_in;
    assign bus.HIin     = en_q.hi_in;
    assign bus.LOin     = en_q.lo_in;
    assign bus.Read     = en_q.read;
    assign bus.IncPC    = en_q.inc_pc;
    assign bus.reg_out  = en_q.reg_out;
    assign bus.reg_in   = en_q.reg_in;
    assign bus.alu_op   = en_q.alu_op;
    assign bus.busy     = en_q.busy;
    assign bus.illegal  = en_q.illegal;

    // At most one source may drive the shared bus in any cycle.
    a_single_driver: assert property (@(posedge clk) disable iff (clr)
        $countones({en_q.pc_out, en_q.zlow_out, en_q.zhigh_out, en_q.mdr_out,
                    en_q.hi_out, en_q.lo_out, en_q.reg_out}) <= 1);

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: per-cycle enable checks from a vector table, plus a
// small bus datapath whose register writebacks are checked against a scoreboard.
module tb_alu_instr_sequencer;
    import alu_instr_sequencer_pkg::*;

    localparam logic [17:0] F_PCOUT = 18'h20000, F_ZLOW  = 18'h10000, F_ZHIGH = 18'h08000;
    localparam logic [17:0] F_MDROUT = 18'h04000, F_MARIN = 18'h00800, F_MDRIN = 18'h00400;
    localparam logic [17:0] F_PCIN  = 18'h00200, F_IRIN  = 18'h00100, F_YIN   = 18'h00080;
    localparam logic [17:0] F_ZIN   = 18'h00040, F_HIIN  = 18'h00020, F_LOIN  = 18'h00010;
    localparam logic [17:0] F_READ  = 18'h00008, F_INCPC = 18'h00004, F_BUSY  = 18'h00002;
    localparam logic [17:0] F_ILL   = 18'h00001;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        logic        chain;
        logic [15:0] t3_out;
        logic [15:0] t4_out;
        logic [3:0]  alu;
        logic [15:0] t5_in;
        logic        muldiv;
        logic [31:0] res;
        logic [31:0] hi;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] dest;
        logic [31:0] val;
    } wb_t;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    alu_instr_sequencer_if bus ();
    alu_instr_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_pc = 0;
    wb_t  sb[$];
    vec_t vecs[7];

    // Minimal bus datapath driven by the sequencer's enables.
    logic [31:0] rf[16];
    logic [31:0] pc, mar, mdr, irr, y, hi, lo, dbus;
    logic [63:0] z;

    function automatic logic [63:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic inc);
        if (inc) return 64'(b + 32'd1);
        case (op)
            ALU_ADD: return 64'(a + b);
            ALU_SUB: return 64'(a - b);
            ALU_AND: return 64'(a & b);
            ALU_OR:  return 64'(a | b);
            ALU_SHR: return 64'(a >> b[4:0]);
            ALU_SHL: return 64'(a << b[4:0]);
            ALU_ROR: return 64'((a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]})));
            ALU_ROL: return 64'((a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]})));
            ALU_MUL: return 64'(a) * 64'(b);
            ALU_DIV: return (b == 0) ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    always_comb begin
        dbus = 32'd0;
        if (bus.PCout)    dbus = pc;
        if (bus.Zlowout)  dbus = z[31:0];
        if (bus.Zhighout) dbus = z[63:32];
        if (bus.MDRout)   dbus = mdr;
        if (bus.HIout)    dbus = hi;
        if (bus.LOout)    dbus = lo;
        for (int i = 0; i < 16; i++) if (bus.reg_out[i]) dbus = rf[i];
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[2] <= 32'hDB;
            rf[3] <= 32'd2;
            pc <= 0; mar <= 0; mdr <= 0; irr <= 0; y <= 0; hi <= 0; lo <= 0; z <= 0;
        end else begin
            if (bus.MARin) mar <= dbus;
            if (bus.PCin)  pc  <= dbus;
            if (bus.MDRin && bus.Read && bus.mem_rdy) mdr <= bus.ir;
            if (bus.IRin)  irr <= dbus;
            if (bus.Yin)   y   <= dbus;
            if (bus.Zin)   z   <= alu(bus.alu_op, y, dbus, bus.IncPC);
            if (bus.HIin)  hi  <= dbus;
            if (bus.LOin)  lo  <= dbus;
            for (int i = 0; i < 16; i++) if (bus.reg_in[i]) rf[i] <= dbus;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] flags();
        return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout,
                bus.MARin, bus.MDRin, bus.PCin, bus.IRin, bus.Yin, bus.Zin, bus.HIin,
                bus.LOin, bus.Read, bus.IncPC, bus.busy, bus.illegal};
    endfunction

    task automatic chk_cyc(input string name, input logic [17:0] f, input logic [15:0] ro,
                           input logic [15:0] ri, input logic [3:0] aop);
        chk(name, 64'({flags(), bus.reg_out, bus.reg_in, bus.alu_op}), 64'({f, ro, ri, aop}));
    endtask

    // Scoreboard: every register/LO/HI writeback must match the next expected entry.
    always @(negedge clk) begin
        if (!clr && ((|bus.reg_in) || bus.LOin || bus.HIin)) begin
            wb_t got, exp;
            got.kind = bus.LOin ? 2'd1 : (bus.HIin ? 2'd2 : 2'd0);
            got.dest = bus.reg_in;
            got.val  = dbus;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: write kind %0d dest 0x%0h val 0x%0h, none expected",
                         got.kind, got.dest, got.val);
            end else begin
                exp = sb.pop_front();
                chk("sb_writeback", 64'({got.kind, got.dest, got.val}),
                    64'({exp.kind, exp.dest, exp.val}));
            end
        end
    end

    // Entered just after a negedge where the next edge moves the FSM into T0.
    task automatic exec_instr(input vec_t v, input string tag);
        bus.ir  = v.ir;
        bus.run = 1'b1;
        if (v.muldiv) begin
            sb.push_back('{2'd1, 16'h0, v.res});
            sb.push_back('{2'd2, 16'h0, v.hi});
        end else begin
            sb.push_back('{2'd0, v.t5_in, v.res});
        end
        @(negedge clk);
        chk_cyc({tag, "_t0"}, F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY, 0, 0, ALU_ADD);
        bus.run     = 1'b0;
        bus.mem_rdy = (v.waits == 0);
        @(negedge clk);
        chk_cyc({tag, "_t1"}, F_ZLOW | F_PCIN | F_READ | F_MDRIN | F_BUSY, 0, 0, 0);
        for (int w = 0; w < v.waits; w++) begin
            @(negedge clk);
            chk_cyc({tag, "_t1w"}, F_READ | F_MDRIN | F_BUSY, 0, 0, 0);
            bus.mem_rdy = (w == v.waits - 1);
        end
        @(negedge clk);
        chk_cyc({tag, "_t2"}, F_MDROUT | F_IRIN | F_BUSY, 0, 0, 0);
        bus.mem_rdy = 1'b0;
        @(negedge clk);
        chk_cyc({tag, "_t3"}, F_YIN | F_BUSY, v.t3_out, 0, 0);
        @(negedge clk);
        chk_cyc({tag, "_t4"}, F_ZIN | F_BUSY, v.t4_out, 0, v.alu);
        @(negedge clk);
        if (v.muldiv) begin
            chk_cyc({tag, "_t5"}, F_ZLOW | F_LOIN | F_BUSY, 0, 0, 0);
            @(negedge clk);
            chk_cyc({tag, "_t6"}, F_ZHIGH | F_HIIN | F_BUSY, 0, 0, 0);
        end else begin
            chk_cyc({tag, "_t5"}, F_ZLOW | F_BUSY, 0, v.t5_in, 0);
        end
        exp_pc++;
        chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
        chk({tag, "_ir"}, 64'(irr), 64'(v.ir));
        bus.run = v.chain;
        if (!v.chain) begin
            @(negedge clk);
            chk_cyc({tag, "_idle"}, 0, 0, 0, 0);
        end
    endtask

    initial begin
        //          ir            waits chain t3_out    t4_out    alu      t5_in     md    res         hi
        vecs[0] = '{32'h28918000, 0, 1'b1, 16'h0004, 16'h0008, ALU_AND, 16'h0002, 1'b0, 32'h02,  32'h0};
        vecs[1] = '{32'h40918000, 0, 1'b0, 16'h0004, 16'h0008, ALU_SHL, 16'h0002, 1'b0, 32'h36C, 32'h0};
        vecs[2] = '{32'h78918000, 0, 1'b1, 16'h0004, 16'h0008, ALU_MUL, 16'h0000, 1'b1, 32'h1B6, 32'h0};
        vecs[3] = '{32'h80118000, 2, 1'b0, 16'h0004, 16'h0008, ALU_DIV, 16'h0000, 1'b1, 32'h6D,  32'h1};
        vecs[4] = '{32'h28918000, 3, 1'b0, 16'h0004, 16'h0008, ALU_AND, 16'h0002, 1'b0, 32'h02,  32'h0};
        vecs[5] = '{32'h1A118000, 1, 1'b1, 16'h0004, 16'h0008, ALU_ADD, 16'h0010, 1'b0, 32'hDD,  32'h0};
        vecs[6] = '{32'h21110000, 0, 1'b0, 16'h0004, 16'h0004, ALU_SUB, 16'h0004, 1'b0, 32'h0,   32'h0};

        clr = 1'b1; bus.run = 1'b0; bus.mem_rdy = 1'b0; bus.ir = 32'd0;
        @(negedge clk);
        chk_cyc("reset", 0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cyc("idle_hold", 0, 0, 0, 0);
        end

        for (int i = 0; i < 7; i++) exec_instr(vecs[i], $sformatf("v%0d", i));

        // Reset in T4 aborts the instruction with no writeback afterwards.
        bus.ir = 32'h28918000; bus.run = 1'b1;
        @(negedge clk); bus.run = 1'b0; bus.mem_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk_cyc("abort_t4", F_ZIN | F_BUSY, 16'h0008, 0, ALU_AND);
        clr = 1'b1;
        #1 chk_cyc("abort_clr", 0, 0, 0, 0);
        @(negedge clk);
        clr = 1'b0; bus.mem_rdy = 1'b0; exp_pc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cyc("abort_idle", 0, 0, 0, 0);
        end

        // Undefined opcode: one-cycle illegal pulse, NOP back to T0, then fetch HALT.
        bus.ir = 32'hF8000000; bus.run = 1'b1;
        @(negedge clk);
        chk_cyc("ill_t0", F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY, 0, 0, ALU_ADD);
        bus.run = 1'b0; bus.mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk_cyc("ill_t2", F_MDROUT | F_IRIN | F_BUSY, 0, 0, 0);
        @(negedge clk);
        chk_cyc("ill_t3", F_ILL | F_BUSY, 0, 0, 0);
        bus.ir = 32'hD8000000;
        @(negedge clk);
        chk_cyc("ill_nop_t0", F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY, 0, 0, ALU_ADD);
        repeat (2) @(negedge clk);
        chk_cyc("halt_t2", F_MDROUT | F_IRIN | F_BUSY, 0, 0, 0);
        @(negedge clk);
        chk_cyc("halt", 0, 0, 0, 0);
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cyc("halt_hold", 0, 0, 0, 0);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk_cyc("post_halt_t0", F_PCOUT | F_MARIN | F_INCPC | F_ZIN | F_BUSY, 0, 0, ALU_ADD);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
